// File: rtl/ps2_note_tracker.sv
// PS/2 receiver with a make/break decoder that tracks up to NUM_SLOTS held keys.
// Slot i holds the scan code of one held key; a free slot reads back as 8'hF0.
module ps2_note_tracker #(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    output logic [8*NUM_SLOTS-1:0] notes,
    output logic [NUM_SLOTS-1:0]   note_valid,
    output logic [7:0]             code,
    output logic                   code_strobe,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_c;

    state_t        state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          par, par_next;
    logic [TW-1:0] tmo_cnt, tmo_next;
    logic          byte_ok_c, perr_c, ferr_c;

    logic                 brk, ext;
    logic                 hit_c;
    logic                 free_found_c;
    logic [NUM_SLOTS-1:0] free_oh_c;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall_c = clk_prev & ~clk_s;

    // Synchronizers idle high so reset never manufactures a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            par     <= par_next;
            tmo_cnt <= tmo_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        par_next     = par;
        tmo_next     = tmo_cnt;
        byte_ok_c    = 1'b0;
        perr_c       = 1'b0;
        ferr_c       = 1'b0;

        if (state != IDLE) begin
            tmo_next = fall_c ? '0 : tmo_cnt + TW'(1);
        end

        case (state)
            IDLE: begin
                tmo_next = '0;
                if (fall_c) begin
                    if (!data_s) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        ferr_c = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_next   = {data_s, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_c) begin
                    par_next   = data_s;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    state_next = IDLE;
                    if (!(^{shift, par})) begin
                        perr_c = 1'b1;
                    end else if (!data_s) begin
                        ferr_c = 1'b1;
                    end else begin
                        byte_ok_c = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A stalled device abandons the partial frame
        if (state != IDLE && !fall_c && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
            tmo_next   = '0;
            ferr_c     = 1'b1;
            perr_c     = 1'b0;
            byte_ok_c  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code        <= 8'h00;
            code_strobe <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            code_strobe <= byte_ok_c;
            parity_err  <= perr_c;
            frame_err   <= ferr_c;
            if (byte_ok_c) begin
                code <= shift;
            end
        end
    end

    // Lowest free slot and whether the current code is already held
    always_comb begin
        hit_c        = 1'b0;
        free_found_c = 1'b0;
        free_oh_c    = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!note_valid[i] && !free_found_c) begin
                free_found_c = 1'b1;
                free_oh_c[i] = 1'b1;
            end
            if (note_valid[i] && notes[8*i +: 8] == code) begin
                hit_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            notes      <= {NUM_SLOTS{8'hF0}};
            note_valid <= '0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (code_strobe) begin
                if (code == 8'hF0) begin
                    brk <= 1'b1;
                end else if (code == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (!ext && brk) begin
                        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                            if (note_valid[i] && notes[8*i +: 8] == code) begin
                                notes[8*i +: 8] <= 8'hF0;
                                note_valid[i]   <= 1'b0;
                            end
                        end
                    end else if (!ext && !hit_c) begin
                        if (free_found_c) begin
                            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                                if (free_oh_c[i]) begin
                                    notes[8*i +: 8] <= code;
                                    note_valid[i]   <= 1'b1;
                                end
                            end
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Directed bench for ps2_note_tracker: bit-banged PS/2 frames, pulse counters, hand-computed slot images.
module tb_ps2_note_tracker;

    localparam int unsigned TMO = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] notes;
    logic [3:0]  note_valid;
    logic [7:0]  code;
    logic        code_strobe, parity_err, frame_err, overflow;

    ps2_note_tracker #(
        .NUM_SLOTS(4), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .notes(notes), .note_valid(note_valid), .code(code),
        .code_strobe(code_strobe), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
    int b_strobe, b_perr, b_ferr, b_ovf;
    logic [31:0] notes_at_strobe, notes_after;
    logic [3:0]  valid_after;
    logic        grab_next = 1'b0;

    // Pulse counters sampled mid-cycle; a stretched pulse counts twice
    always @(negedge clk) begin
        if (code_strobe) begin
            n_strobe++;
            notes_at_strobe = notes;
            grab_next = 1'b1;
        end else if (grab_next) begin
            notes_after = notes;
            valid_after = note_valid;
            grab_next = 1'b0;
        end
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (overflow)   n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_strobe = n_strobe; b_perr = n_perr; b_ferr = n_ferr; b_ovf = n_ovf;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par = 1'b0, input logic stop = 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_notes"}, notes, 32'hF0F0F0F0);
        check({tag, "_valid"}, 32'(note_valid), 32'h0);
        check({tag, "_code"}, 32'(code), 32'h0);
        check({tag, "_pulses"}, 32'({code_strobe, parity_err, frame_err, overflow}), 32'h0);
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single make lands in slot 0 one cycle after the strobe
        snap();
        frame(8'h1C);
        check("make_strobes", 32'(n_strobe - b_strobe), 32'd1);
        check("make_code", 32'(code), 32'h1C);
        check("make_pre_slot", notes_at_strobe, 32'hF0F0F0F0);
        check("make_post_slot", notes_after, 32'hF0F0F01C);
        check("make_post_valid", 32'(valid_after), 32'h1);

        // Fill all slots, then overflow
        frame(8'h1B); frame(8'h23); frame(8'h2B);
        check("full_notes", notes, 32'h2B231B1C);
        check("full_valid", 32'(note_valid), 32'hF);
        snap();
        frame(8'h34);
        check("ovf_pulse", 32'(n_ovf - b_ovf), 32'd1);
        check("ovf_notes", notes, 32'h2B231B1C);
        check("ovf_code", 32'(code), 32'h34);

        // Breaks free slots in place; next make takes lowest free
        frame(8'hF0); frame(8'h23); frame(8'hF0); frame(8'h2B);
        check("brk2_notes", notes, 32'hF0F01B1C);
        frame(8'hF0); frame(8'h1C);
        check("brk_notes", notes, 32'hF0F01BF0);
        check("brk_valid", 32'(note_valid), 32'h2);
        frame(8'h23);
        check("refill_notes", notes, 32'hF0F01B23);
        check("refill_valid", 32'(note_valid), 32'h3);

        // Typematic repeat and extended codes
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0; repeat (2) @(negedge clk);
        snap();
        frame(8'h1C); frame(8'h1C); frame(8'h1C);
        check("rep_notes", notes, 32'hF0F0F01C);
        check("rep_ovf", 32'(n_ovf - b_ovf), 32'd0);
        check("rep_strobes", 32'(n_strobe - b_strobe), 32'd3);
        snap();
        frame(8'hE0); frame(8'h1C);
        check("ext_strobes", 32'(n_strobe - b_strobe), 32'd2);
        check("ext_code", 32'(code), 32'h1C);
        check("ext_notes", notes, 32'hF0F0F01C);
        frame(8'hE0); frame(8'hF0); frame(8'h1C);
        check("extbrk_notes", notes, 32'hF0F0F01C);
        frame(8'hF0); frame(8'h55);
        check("brk_miss_notes", notes, 32'hF0F0F01C);
        frame(8'h2B);
        check("flags_clear_make", notes, 32'hF0F02B1C);

        // Frame errors
        snap();
        frame(8'h33, 1'b1);
        check("par_perr", 32'(n_perr - b_perr), 32'd1);
        check("par_strobe", 32'(n_strobe - b_strobe), 32'd0);
        snap();
        frame(8'h33, 1'b0, 1'b0);
        check("stop_ferr", 32'(n_ferr - b_ferr), 32'd1);
        check("stop_strobe", 32'(n_strobe - b_strobe), 32'd0);
        snap();
        frame(8'h33, 1'b1, 1'b0);
        check("both_perr", 32'(n_perr - b_perr), 32'd1);
        check("both_ferr", 32'(n_ferr - b_ferr), 32'd0);
        snap();
        ps2_bit(1'b1);
        check("start_ferr", 32'(n_ferr - b_ferr), 32'd1);
        check("err_notes", notes, 32'hF0F02B1C);

        // Timeout after 4 data bits
        snap();
        partial(4);
        repeat (TMO - 40) @(negedge clk);
        check("tmo_early", 32'(n_ferr - b_ferr), 32'd0);
        repeat (60) @(negedge clk);
        check("tmo_ferr", 32'(n_ferr - b_ferr), 32'd1);
        check("tmo_strobe", 32'(n_strobe - b_strobe), 32'd0);
        frame(8'h34);
        check("tmo_recover_code", 32'(code), 32'h34);
        check("tmo_recover_notes", notes, 32'hF0342B1C);

        // Reset mid-frame
        partial(5);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        snap();
        frame(8'h1B);
        check("post_rst_strobe", 32'(n_strobe - b_strobe), 32'd1);
        check("post_rst_code", 32'(code), 32'h1B);
        check("post_rst_notes", notes, 32'hF0F0F01B);
        check("post_rst_errs", 32'((n_ferr - b_ferr) + (n_perr - b_perr)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
